// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter: frame state encoding, data
// width and the default bit period (50 MHz clock, 115200 baud).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 434;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 and raises tick during the last
// cycle of each bit, then wraps to 0 so the next bit starts with a fresh count.
//
// Ports
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears the counter
//   clear : hold the counter at 0 (used while the transmitter is idle)
//   tick  : high in the final cycle of the current bit period
// -----------------------------------------------------------------------------
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int              CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_MAX);

    // Every state change of the transmitter happens either out of IDLE
    // (counter held at 0 by clear) or on tick (counter wraps to 0), so the
    // count always restarts at 0 on entry to a new bit.
    always_comb begin
        if (clear || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_core.sv
// -----------------------------------------------------------------------------
// uart_tx_core
// 8N1 UART transmitter with optional even parity. A byte is accepted on any
// rising edge where the core is idle and uart_wr_i is high; the frame is
// start(0), 8 data bits LSB first, optional parity, stop(1). All outputs are
// registered and reflect the state entered on the same edge.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset, aborts any frame
//   uart_dat_i : byte to send, sampled only on acceptance
//   uart_wr_i  : write request, level sensitive, ignored while busy
//   uart_busy  : high for the whole frame, low in every idle cycle
//   uart_tx    : serial line, idles high
//   tx_done    : one-cycle pulse in the first idle cycle after a frame
// -----------------------------------------------------------------------------
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] uart_dat_i,
    input  logic       uart_wr_i,
    output logic       uart_busy,
    output logic       uart_tx,
    output logic       tx_done
);

    localparam int               IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    uart_state_e          state_q,  state_d;
    logic [DATA_BITS-1:0] shift_q,  shift_d;
    logic [IDX_W-1:0]     idx_q,    idx_d;
    logic                 parity_q, parity_d;
    logic                 tx_q,     tx_d;
    logic                 busy_q,   busy_d;
    logic                 done_q,   done_d;

    logic tick;
    logic baud_clear;

    assign baud_clear = (state_q == IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (baud_clear),
        .tick  (tick)
    );

    // Next-state logic. tx_d is the line level for the state being entered,
    // so the registered line changes on the same edge as the state.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        parity_d = parity_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (uart_wr_i) begin
                    state_d  = START;
                    shift_d  = uart_dat_i;
                    parity_d = ^uart_dat_i;
                    idx_d    = '0;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        if (PARITY_EN) begin
                            state_d = PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        // Bit 0 of the shift register is always the bit on
                        // the line; bit 1 is the one about to be sent.
                        idx_d   = idx_q + 1'b1;
                        shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign uart_tx   = tx_q;
    assign uart_busy = busy_q;
    assign tx_done   = done_q;

endmodule
